// File: rtl/ddr2_app_req_packer.sv
// ----------------------------------------------------------------------------
// ddr2_app_req_packer
//
// Packs whole-burst user read/write requests into DDR2 backend FIFO writes.
// Each request produces one command word in the address FIFO. A write burst
// also produces two beats in the write-data FIFO: the low half first, then
// the high half. All app_* outputs are registered. They follow the FSM state
// by one cycle, so a request accepted at edge N shows its command (and write
// beat 0) after edge N+1, and its write beat 1 after edge N+2.
//
// Optional build macro: DDR2_PACKER_STATS_EN
//   When defined, the block adds the stat_wr_cnt and stat_rd_cnt counter
//   outputs (16-bit, wrapping). When undefined, these ports do not exist.
//
// Ports:
//   clk0            sole clock
//   rst_n           synchronous active-low reset
//   init_done       memory calibration complete; gates new accepts only
//   usr_valid       request valid
//   usr_ready       request accepted on an edge where usr_valid & usr_ready
//   usr_cmd         0 = write, 1 = read
//   usr_addr        burst address (zero-extended to 32 bits)
//   usr_wdata       burst data; the low half is beat 0
//   usr_wmask       burst mask (1 = masked); the low half is beat 0
//   af_almost_full  address FIFO almost full
//   wdf_almost_full data FIFO almost full
//   app_af_addr     command word {1'b0, cmd[2:0], addr[31:0]}
//   app_af_wren     address FIFO write strobe
//   app_wdf_data    data FIFO beat
//   app_mask_data   mask beat (all-ones when the data FIFO is idle)
//   app_wdf_wren    data FIFO write strobe
//   req_busy        high whenever the FSM is not IDLE
//   stat_wr_cnt     (DDR2_PACKER_STATS_EN) number of WR0 cycles, wrapping
//   stat_rd_cnt     (DDR2_PACKER_STATS_EN) number of RD cycles, wrapping
// ----------------------------------------------------------------------------
module ddr2_app_req_packer #(
    parameter int DQ_WIDTH   = 32,
    parameter int DM_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk0,
    input  logic                    rst_n,
    input  logic                    init_done,
    input  logic                    usr_valid,
    output logic                    usr_ready,
    input  logic                    usr_cmd,
    input  logic [ADDR_WIDTH-1:0]   usr_addr,
    input  logic [4*DQ_WIDTH-1:0]   usr_wdata,
    input  logic [4*DM_WIDTH-1:0]   usr_wmask,
    input  logic                    af_almost_full,
    input  logic                    wdf_almost_full,
    output logic [35:0]             app_af_addr,
    output logic                    app_af_wren,
    output logic [2*DQ_WIDTH-1:0]   app_wdf_data,
    output logic [2*DM_WIDTH-1:0]   app_mask_data,
    output logic                    app_wdf_wren,
    output logic                    req_busy
`ifdef DDR2_PACKER_STATS_EN
    ,
    output logic [15:0]             stat_wr_cnt,
    output logic [15:0]             stat_rd_cnt
`endif
);

    localparam int BEAT_W = 2 * DQ_WIDTH;
    localparam int MASK_W = 2 * DM_WIDTH;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        IDLE,
        WR0,
        WR1,
        RD
    } state_t;

    state_t state, state_next;

    // Request holding register, loaded on accept (data path, not reset)
    logic [ADDR_WIDTH-1:0]  addr_p0;
    logic [4*DQ_WIDTH-1:0]  wdata_p0;
    logic [4*DM_WIDTH-1:0]  wmask_p0;

    // Next values for the registered app_* outputs
    logic                   af_wren_d;
    logic [35:0]            af_addr_d;
    logic                   wdf_wren_d;
    logic [BEAT_W-1:0]      wdf_data_d;
    logic [MASK_W-1:0]      mask_d;

    logic                   accept;

    function automatic logic [35:0] cmd_word(input logic [2:0] cmd,
                                             input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, cmd, 32'(addr)};
    endfunction

    // Ready never looks at usr_valid/usr_cmd, so upstream may wait on it.
    always_comb begin
        usr_ready = init_done & ~af_almost_full & ~wdf_almost_full & (state != WR0);
        accept    = usr_valid & usr_ready;
        req_busy  = (state != IDLE);
    end

    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        af_wren_d  = 1'b0;
        af_addr_d  = '0;
        wdf_wren_d = 1'b0;
        wdf_data_d = '0;
        mask_d     = '1;
        case (state)
            IDLE: begin
                if (accept) state_next = usr_cmd ? RD : WR0;
            end
            WR0: begin
                af_wren_d  = 1'b1;
                af_addr_d  = cmd_word(CMD_WR, addr_p0);
                wdf_wren_d = 1'b1;
                wdf_data_d = wdata_p0[BEAT_W-1:0];
                mask_d     = wmask_p0[MASK_W-1:0];
                state_next = WR1;
            end
            WR1: begin
                // The next request can be taken here, which keeps W->R gapless.
                wdf_wren_d = 1'b1;
                wdf_data_d = wdata_p0[2*BEAT_W-1:BEAT_W];
                mask_d     = wmask_p0[2*MASK_W-1:MASK_W];
                state_next = accept ? (usr_cmd ? RD : WR0) : IDLE;
            end
            RD: begin
                af_wren_d  = 1'b1;
                af_addr_d  = cmd_word(CMD_RD, addr_p0);
                state_next = accept ? (usr_cmd ? RD : WR0) : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: capture the accepted request. In WR1 this overwrites the
    // burst being finished, which is safe because its high half is already
    // in wdf_data_d and lands in the output register on the same edge.
    always_ff @(posedge clk0) begin
        if (accept) begin
            addr_p0  <= usr_addr;
            wdata_p0 <= usr_wdata;
            wmask_p0 <= usr_wmask;
        end
    end

    // Stage p1: registered FIFO write outputs
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            app_af_wren   <= 1'b0;
            app_af_addr   <= '0;
            app_wdf_wren  <= 1'b0;
            app_wdf_data  <= '0;
            app_mask_data <= '1;
        end else begin
            app_af_wren   <= af_wren_d;
            app_af_addr   <= af_addr_d;
            app_wdf_wren  <= wdf_wren_d;
            app_wdf_data  <= wdf_data_d;
            app_mask_data <= mask_d;
        end
    end

`ifdef DDR2_PACKER_STATS_EN
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            stat_wr_cnt <= '0;
            stat_rd_cnt <= '0;
        end else begin
            if (state == WR0) stat_wr_cnt <= stat_wr_cnt + 16'd1;
            if (state == RD)  stat_rd_cnt <= stat_rd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_app_req_packer.sv
// ----------------------------------------------------------------------------
// Bench for ddr2_app_req_packer. The reference model is a schedule of the
// FIFO writes each accepted request owes: one slot per future clock edge.
// The DUT outputs are compared against the slot that falls due at each edge.
// ----------------------------------------------------------------------------
module tb_ddr2_app_req_packer;

    localparam int DQ_WIDTH   = 32;
    localparam int DM_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;

    logic                  clk0 = 1'b0;
    logic                  rst_n;
    logic                  init_done;
    logic                  usr_valid;
    logic                  usr_ready;
    logic                  usr_cmd;
    logic [ADDR_WIDTH-1:0] usr_addr;
    logic [4*DQ_WIDTH-1:0] usr_wdata;
    logic [4*DM_WIDTH-1:0] usr_wmask;
    logic                  af_almost_full;
    logic                  wdf_almost_full;
    logic [35:0]           app_af_addr;
    logic                  app_af_wren;
    logic [2*DQ_WIDTH-1:0] app_wdf_data;
    logic [2*DM_WIDTH-1:0] app_mask_data;
    logic                  app_wdf_wren;
    logic                  req_busy;
`ifdef DDR2_PACKER_STATS_EN
    logic [15:0]           stat_wr_cnt;
    logic [15:0]           stat_rd_cnt;
`endif

    always #5 clk0 = ~clk0;

    ddr2_app_req_packer #(
        .DQ_WIDTH   (DQ_WIDTH),
        .DM_WIDTH   (DM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk0            (clk0),
        .rst_n           (rst_n),
        .init_done       (init_done),
        .usr_valid       (usr_valid),
        .usr_ready       (usr_ready),
        .usr_cmd         (usr_cmd),
        .usr_addr        (usr_addr),
        .usr_wdata       (usr_wdata),
        .usr_wmask       (usr_wmask),
        .af_almost_full  (af_almost_full),
        .wdf_almost_full (wdf_almost_full),
        .app_af_addr     (app_af_addr),
        .app_af_wren     (app_af_wren),
        .app_wdf_data    (app_wdf_data),
        .app_mask_data   (app_mask_data),
        .app_wdf_wren    (app_wdf_wren),
        .req_busy        (req_busy)
`ifdef DDR2_PACKER_STATS_EN
        ,
        .stat_wr_cnt     (stat_wr_cnt),
        .stat_rd_cnt     (stat_rd_cnt)
`endif
    );

    typedef struct packed {
        logic        af;
        logic [35:0] addr;
        logic        wdf;
        logic [63:0] data;
        logic [7:0]  mask;
    } slot_t;

    slot_t cur, n1, n2;
    int    n_checks = 0;
    int    n_errors = 0;
    int    af_seen, wdf_seen, act_seen;
    logic [15:0] exp_wr_cnt, exp_rd_cnt;

    function automatic slot_t idle_slot();
        slot_t s;
        s      = '0;
        s.mask = '1;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur        = idle_slot();
        n1         = idle_slot();
        n2         = idle_slot();
        exp_wr_cnt = '0;
        exp_rd_cnt = '0;
    endtask

    // One clock: check ready/busy before the edge, advance the model on the
    // edge, check the registered outputs just after it.
    task automatic step(output logic acc);
        logic rdy_exp;
        #1;
        // A write accepted last edge still owes its command + beat 0 next edge.
        rdy_exp = init_done & ~af_almost_full & ~wdf_almost_full & ~(n1.af & n1.wdf);
        chk("usr_ready", 64'(usr_ready), 64'(rdy_exp));
        chk("req_busy", 64'(req_busy), 64'(n1.af | n1.wdf));
        acc = usr_valid & rdy_exp;
        @(posedge clk0);
        if (!rst_n) begin
            model_reset();
        end else begin
            cur = n1;
            n1  = n2;
            n2  = idle_slot();
            if (acc) begin
                n1.af = 1'b1;
                if (!usr_cmd) begin
                    n1.addr = {4'b0000, 32'(usr_addr)};
                    n1.wdf  = 1'b1;
                    n1.data = usr_wdata[63:0];
                    n1.mask = usr_wmask[7:0];
                    n2.wdf  = 1'b1;
                    n2.data = usr_wdata[127:64];
                    n2.mask = usr_wmask[15:8];
                end else begin
                    n1.addr = {4'b0001, 32'(usr_addr)};
                end
            end
            if (cur.af & cur.wdf)  exp_wr_cnt = exp_wr_cnt + 16'd1;
            if (cur.af & ~cur.wdf) exp_rd_cnt = exp_rd_cnt + 16'd1;
        end
        #1;
        chk("af_wren",  64'(app_af_wren),   64'(cur.af));
        chk("af_addr",  64'(app_af_addr),   64'(cur.addr));
        chk("wdf_wren", 64'(app_wdf_wren),  64'(cur.wdf));
        chk("wdf_data", 64'(app_wdf_data),  cur.data);
        chk("mask",     64'(app_mask_data), 64'(cur.mask));
`ifdef DDR2_PACKER_STATS_EN
        chk("stat_wr", 64'(stat_wr_cnt), 64'(exp_wr_cnt));
        chk("stat_rd", 64'(stat_rd_cnt), 64'(exp_rd_cnt));
`endif
        if (app_af_wren)  af_seen++;
        if (app_wdf_wren) wdf_seen++;
        if (app_af_wren | app_wdf_wren) act_seen++;
    endtask

    task automatic drive(input logic v, input logic c, input logic [31:0] a,
                         input logic [127:0] d, input logic [15:0] m);
        usr_valid = v;
        usr_cmd   = c;
        usr_addr  = a;
        usr_wdata = d;
        usr_wmask = m;
    endtask

    task automatic clr_seen();
        af_seen  = 0;
        wdf_seen = 0;
        act_seen = 0;
    endtask

    logic acc;
    int   steps;
    int   idx;
    logic cmds [4];

    initial begin
        rst_n = 1'b0;
        init_done = 1'b1;
        af_almost_full = 1'b0;
        wdf_almost_full = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        model_reset();
        clr_seen();
        repeat (2) @(posedge clk0);
        #1;

        // Reset values (checked by step against the idle model)
        step(acc);
        chk("rst_mask", 64'(app_mask_data), 64'hFF);
        rst_n = 1'b1;
        step(acc);

        // Single write
        clr_seen();
        drive(1'b1, 1'b0, 32'h0000_1234,
              {{16{4'hA}}, {16{4'h5}}}, 16'h0000);
        step(acc);
        chk("wr_accept", 64'(acc), 64'd1);
        usr_valid = 1'b0;
        step(acc);
        chk("wr_cmd_word", 64'(app_af_addr), 64'h0_0000_1234);
        chk("wr_beat0", app_wdf_data, 64'h5555_5555_5555_5555);
        step(acc);
        chk("wr_beat1", app_wdf_data, 64'hAAAA_AAAA_AAAA_AAAA);
        repeat (2) step(acc);
        chk("wr_af_count", 64'(af_seen), 64'd1);
        chk("wr_wdf_count", 64'(wdf_seen), 64'd2);

        // Single read
        clr_seen();
        drive(1'b1, 1'b1, 32'h0000_0040, '0, '0);
        step(acc);
        usr_valid = 1'b0;
        step(acc);
        chk("rd_cmd_word", 64'(app_af_addr), 64'h1_0000_0040);
        repeat (2) step(acc);
        chk("rd_wdf_count", 64'(wdf_seen), 64'd0);

        // Alternating W,R,W,R with valid held
        clr_seen();
        cmds[0] = 1'b0; cmds[1] = 1'b1; cmds[2] = 1'b0; cmds[3] = 1'b1;
        idx = 0;
        steps = 0;
        while (idx < 4 && steps < 20) begin
            drive(1'b1, cmds[idx], $urandom, {$urandom, $urandom, $urandom, $urandom},
                  16'($urandom));
            step(acc);
            steps++;
            if (acc) idx++;
        end
        usr_valid = 1'b0;
        step(acc);
        chk("alt_accept_cycles", 64'(steps), 64'd6);
        chk("alt_active_edges", 64'(act_seen), 64'd6);
        chk("alt_af_count", 64'(af_seen), 64'd4);
        chk("alt_wdf_count", 64'(wdf_seen), 64'd4);
        step(acc);

        // Almost-full rises during WR0: burst still completes
        clr_seen();
        drive(1'b1, 1'b0, 32'h0000_0100, {4{32'hDEAD_BEEF}}, 16'h0F0F);
        step(acc);
        af_almost_full = 1'b1;
        step(acc);
        step(acc);
        chk("af_full_beat1", 64'(app_wdf_wren), 64'd1);
        repeat (3) begin
            step(acc);
            chk("af_full_ready", 64'(usr_ready), 64'd0);
        end
        af_almost_full = 1'b0;
        step(acc);
        chk("af_drop_accept", 64'(acc), 64'd1);
        usr_valid = 1'b0;
        repeat (3) step(acc);

        // init_done low blocks accepts
        clr_seen();
        init_done = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_0200, '0, '0);
        repeat (20) step(acc);
        chk("init_no_writes", 64'(af_seen + wdf_seen), 64'd0);
        init_done = 1'b1;
        step(acc);
        usr_valid = 1'b0;
        step(acc);
        chk("init_accept_af", 64'(app_af_wren), 64'd1);
        step(acc);

        // Reset during WR0 abandons beat 1
        clr_seen();
        drive(1'b1, 1'b0, 32'h0000_0300, {4{32'h1234_5678}}, 16'h00FF);
        step(acc);
        usr_valid = 1'b0;
        rst_n = 1'b0;
        step(acc);
        chk("rst_wdf_wren", 64'(app_wdf_wren), 64'd0);
        chk("rst_mask_mid", 64'(app_mask_data), 64'hFF);
        rst_n = 1'b1;
        repeat (3) step(acc);
        chk("rst_no_beats", 64'(wdf_seen), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n           = ($urandom_range(63) != 0);
            init_done       = ($urandom_range(15) != 0);
            af_almost_full  = ($urandom_range(7) == 0);
            wdf_almost_full = ($urandom_range(7) == 0);
            drive(1'($urandom_range(3) != 0), 1'($urandom), $urandom,
                  {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            step(acc);
        end
        rst_n = 1'b1;
        usr_valid = 1'b0;
        repeat (3) step(acc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
